// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset CPU: one shared ALU, unified word-addressed instruction/data memory.
// Define MULTICYCLE_BNE_EN to add bne (opcode 0x05); MEM_WORDS must be a power of two.
module cpu_multicycle #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic [5:0]  OPCODE,
  output logic [3:0]  STATE
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OpBne   = 6'h05;
`endif
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSlt   = 6'h2A;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  typedef enum logic [1:0] {SrcB, SrcFour, SrcImm, SrcImmSh} alu_b_sel_e;
  typedef enum logic [1:0] {PcAlu, PcAluOut, PcJump} pc_src_e;

  state_e     state_q, state_d;
  logic [31:0] ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic [31:0] rf_q [32];

  // Control signals
  logic       ir_write, pc_write, iord, mem_write, ab_load, alu_out_load, mdr_load;
  logic       alu_a_pc, alu_slt, rf_write, rf_dst_rd, rf_src_mdr;
  alu_b_sel_e alu_b_sel;
  pc_src_e    pc_src;

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, rf_waddr;
  logic [31:0]   sext, alu_a, alu_b, alu_y, pc_next, mem_addr, mem_rdata, rf_wdata;
  logic [AW-1:0] mem_idx;
  logic          funct_ok, a_eq_b, branch_take;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign funct_ok = (funct == FnAdd) || (funct == FnSlt);
  assign a_eq_b   = (a_q == b_q);

`ifdef MULTICYCLE_BNE_EN
  assign branch_take = (opcode == OpBne) ? !a_eq_b : a_eq_b;
`else
  assign branch_take = a_eq_b;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = funct_ok ? StExec : StFetch;
          OpAddi:     state_d = StAddiEx;
          OpBeq:      state_d = StBranch;
`ifdef MULTICYCLE_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PcAlu;
    iord         = 1'b0;
    mem_write    = 1'b0;
    ab_load      = 1'b0;
    alu_out_load = 1'b0;
    alu_a_pc     = 1'b1;
    alu_b_sel    = SrcFour;
    alu_slt      = 1'b0;
    mdr_load     = 1'b0;
    rf_write     = 1'b0;
    rf_dst_rd    = 1'b0;
    rf_src_mdr   = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      // ALU is idle in decode, so it precomputes the branch target speculatively
      StDecode: begin
        ab_load      = 1'b1;
        alu_out_load = 1'b1;
        alu_b_sel    = SrcImmSh;
      end
      StMemAdr, StAddiEx: begin
        alu_a_pc     = 1'b0;
        alu_b_sel    = SrcImm;
        alu_out_load = 1'b1;
      end
      StMemRd: begin
        iord     = 1'b1;
        mdr_load = 1'b1;
      end
      StMemWb: begin
        rf_write   = 1'b1;
        rf_src_mdr = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StExec: begin
        alu_a_pc     = 1'b0;
        alu_b_sel    = SrcB;
        alu_slt      = (funct == FnSlt);
        alu_out_load = 1'b1;
      end
      StAluWb: begin
        rf_write  = 1'b1;
        rf_dst_rd = 1'b1;
      end
      StBranch: begin
        pc_src   = PcAluOut;
        pc_write = branch_take;
      end
      StJump: begin
        pc_src   = PcJump;
        pc_write = 1'b1;
      end
      StAddiWb: rf_write = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared ALU and PC select
  // ---------------------------------------------------------------------------
  assign alu_a = alu_a_pc ? PC : a_q;

  always_comb begin
    alu_b = b_q;
    unique case (alu_b_sel)
      SrcB:     alu_b = b_q;
      SrcFour:  alu_b = 32'd4;
      SrcImm:   alu_b = sext;
      SrcImmSh: alu_b = {sext[29:0], 2'b00};
      default:  alu_b = b_q;
    endcase
  end

  assign alu_y = alu_slt ? {31'd0, $signed(alu_a) < $signed(alu_b)} : alu_a + alu_b;

  always_comb begin
    case (pc_src)
      PcAluOut: pc_next = alu_out_q;
      PcJump:   pc_next = {PC[31:28], ir_q[25:0], 2'b00};
      default:  pc_next = alu_y;
    endcase
  end

  if (1'b1) begin : b2v_PCR
    logic [31:0] Q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        Q <= '0;
      end else if (pc_write) begin
        Q <= pc_next;
      end
    end
    assign PC = Q;
  end

  // ---------------------------------------------------------------------------
  // Unified memory: combinational read, synchronous write, never reset
  // ---------------------------------------------------------------------------
  assign mem_addr = iord ? alu_out_q : PC;
  assign mem_idx  = mem_addr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  if (1'b1) begin : b2v_IDM
    logic [31:0] memory [MEM_WORDS];
    always_ff @(posedge clk) begin
      if (mem_write) begin
        memory[mem_idx] <= b_q;
      end
    end
    assign mem_rdata = memory[mem_idx];
  end

  // ---------------------------------------------------------------------------
  // Non-architectural datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      if (ir_write) begin
        ir_q <= mem_rdata;
      end
      if (ab_load) begin
        a_q <= rf_q[rs];
        b_q <= rf_q[rt];
      end
      if (alu_out_load) begin
        alu_out_q <= alu_y;
      end
      if (mdr_load) begin
        mdr_q <= mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file; $0 is never written so it always reads zero
  // ---------------------------------------------------------------------------
  assign rf_waddr = rf_dst_rd ? rd : rt;
  assign rf_wdata = rf_src_mdr ? mdr_q : alu_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_write && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign OPCODE = opcode;
  assign STATE  = state_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: random programs checked against an instruction-level model,
// plus asynchronous reset during a store.
module tb_cpu_multicycle;

  localparam int L = 48;  // program length in words; word L holds a parking jump

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [5:0]  OPCODE;
  logic [3:0]  STATE;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  cpu_multicycle dut (
    .clk    (clk),
    .rst    (rst),
    .PC     (PC),
    .OPCODE (OPCODE),
    .STATE  (STATE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Executes one instruction architecturally; returns the expected cycle count.
  task automatic model_step(output int cyc);
    logic [31:0] ins, a, b, sx, pc4, ea;
    int unsigned widx;
    ins  = m_mem[(m_pc / 4) % 256];
    pc4  = m_pc + 32'd4;
    m_pc = pc4;
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    sx   = {{16{ins[15]}}, ins[15:0]};
    ea   = a + sx;
    widx = (ea / 4) % 256;
    cyc  = 2;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h20) begin
          write_reg(ins[15:11], a + b);
          cyc = 4;
        end else if (ins[5:0] == 6'h2A) begin
          write_reg(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          cyc = 4;
        end
      end
      6'h08: begin write_reg(ins[20:16], ea); cyc = 4; end
      6'h23: begin write_reg(ins[20:16], m_mem[widx]); cyc = 5; end
      6'h2B: begin m_mem[widx] = b; cyc = 4; end
      6'h04: begin
        if (a == b) m_pc = pc4 + (sx << 2);
        cyc = 3;
      end
`ifdef MULTICYCLE_BNE_EN
      6'h05: begin
        if (a != b) m_pc = pc4 + (sx << 2);
        cyc = 3;
      end
`endif
      6'h02: begin m_pc = {pc4[31:28], ins[25:0], 2'b00}; cyc = 3; end
      default: cyc = 2;
    endcase
  endtask

  // Random instruction for word i; all control flow is forward so the program ends at word L.
  function automatic logic [31:0] gen(input int i);
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op;
    logic [15:0] imm;
    int k, off;
    rs  = 5'($urandom_range(15, 0));
    rt  = 5'($urandom_range(15, 0));
    rd  = 5'($urandom_range(15, 0));
    imm = 16'($urandom);
    k   = int'($urandom_range(9, 0));
    case (k)
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      2: return {6'h08, rs, rt, imm};
      3, 4: begin
        op = (k == 3) ? 6'h23 : 6'h2B;
        if ($urandom_range(7, 0) == 0) return {op, 5'd0, rt, 16'hFFFC};
        return {op, 5'd16, rt, 16'(4 * $urandom_range(63, 0))};
      end
      5, 6: begin
        op  = (k == 5) ? 6'h04 : 6'h05;
        off = int'($urandom_range(3, 0));
        if (off > L - 1 - i) off = L - 1 - i;
        if ($urandom_range(1, 0) == 1) rt = rs;
        return {op, rs, rt, 16'(off)};
      end
      7: return {6'h02, 26'($urandom_range(L, i + 1))};
      8: return {6'h3F, rs, rt, imm};
      default: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
    endcase
  endfunction

  // Runs the DUT from FETCH until it is back in FETCH, bounded.
  task automatic run_instr(input logic [5:0] exp_op, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
      if (cyc == 1) begin
        check("opcode", 32'(OPCODE), 32'(exp_op));
        check("decode_state", 32'(STATE), 32'd1);
      end
    end while (STATE != 4'd0 && cyc < 8);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int cyc, exp_cyc, guard;
    logic [5:0] exp_op;

    rst = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_mem[0] = {6'h08, 5'd0, 5'd16, 16'd512};            // addi $16,$0,512
    m_mem[1] = {6'h08, 5'd0, 5'd17, 16'd12};             // addi $17,$0,12
    m_mem[2] = {6'h08, 5'd0, 5'd18, 16'd11};             // addi $18,$0,11
    m_mem[3] = {6'h00, 5'd0, 5'd18, 5'd8, 5'd0, 6'h2A};  // slt  $8,$0,$18
    m_mem[4] = {6'h04, 5'd8, 5'd0, 16'd16};              // beq  $8,$0,+16 (not taken)
    m_mem[5] = {6'h08, 5'd0, 5'd8, 16'd0};               // addi $8,$0,0
    m_mem[6] = {6'h04, 5'd8, 5'd0, 16'd1};               // beq  $8,$0,+1 (taken)
    for (int i = 7; i < L; i++) m_mem[i] = gen(i);
    m_mem[L] = {6'h02, 26'(L)};
    for (int i = 128; i < 192; i++) m_mem[i] = $urandom;
    m_mem[255] = $urandom;
    for (int i = 0; i < 256; i++) dut.b2v_IDM.memory[i] = m_mem[i];
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0;

    step();
    step();
    check("reset_pc", PC, 32'd0);
    check("reset_state", 32'(STATE), 32'd0);
    check("reset_opcode", 32'(OPCODE), 32'd0);
    rst = 1'b1;

    guard = 0;
    while (m_pc != 32'(4 * L) && guard < 200) begin
      exp_op = m_mem[(m_pc / 4) % 256][31:26];
      model_step(exp_cyc);
      run_instr(exp_op, cyc);
      check("cycles", 32'(cyc), 32'(exp_cyc));
      check("pc", PC, m_pc);
      guard++;
    end
    for (int r = 0; r < 19; r++) check($sformatf("reg%0d", r), dut.rf_q[r], m_reg[r]);
    for (int w = 128; w < 192; w++) check($sformatf("mem%0d", w), dut.b2v_IDM.memory[w], m_mem[w]);
    check("mem255", dut.b2v_IDM.memory[255], m_mem[255]);

    // Reset in the middle of a store aborts it before the write edge.
    rst = 1'b0;
    dut.b2v_IDM.memory[0]   = {6'h08, 5'd0, 5'd1, 16'd77};    // addi $1,$0,77
    dut.b2v_IDM.memory[1]   = {6'h2B, 5'd0, 5'd1, 16'd1016};  // sw $1,1016($0)
    dut.b2v_IDM.memory[254] = 32'd0;
    step();
    step();
    rst = 1'b1;
    run_instr(6'h08, cyc);
    check("rst_addi_cycles", 32'(cyc), 32'd4);
    for (int i = 0; i < 10; i++) begin
      if (STATE == 4'd5) break;
      step();
    end
    check("reach_memwr", 32'(STATE), 32'd5);
    rst = 1'b0;
    #1;
    check("async_pc", PC, 32'd0);
    check("async_state", 32'(STATE), 32'd0);
    check("async_opcode", 32'(OPCODE), 32'd0);
    check("async_reg1", dut.rf_q[1], 32'd0);
    step();
    check("aborted_store", dut.b2v_IDM.memory[254], 32'd0);
    rst = 1'b1;
    run_instr(6'h08, cyc);
    check("restart_cycles", 32'(cyc), 32'd4);
    check("restart_reg1", dut.rf_q[1], 32'd77);
    check("restart_pc", PC, 32'd4);
    run_instr(6'h2B, cyc);
    check("sw_cycles", 32'(cyc), 32'd4);
    check("sw_mem254", dut.b2v_IDM.memory[254], 32'd77);
    check("sw_pc", PC, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
